// File: rtl/alarm_clock_multi.sv
// Multi-alarm clock: sec/min/hr/day timekeeping on a 1 Hz tick enable, NUM_ALARMS alarms and a ring/snooze FSM.
// Optional macro ALARM_DAYMASK_EN adds a per-alarm, per-day enable input.
module alarm_clock_multi #(
    parameter int NS             = 60,
    parameter int NM             = 60,
    parameter int NH             = 24,
    parameter int ND             = 7,
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 9,
    parameter int RING_TIMEOUT_S = 300,
    parameter int AW             = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  timeset,
    input  logic                  alarmset,
    input  logic                  minadv,
    input  logic                  hrsadv,
    input  logic                  dayadv,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_on,
    input  logic                  snooze,
    input  logic                  dismiss,
`ifdef ALARM_DAYMASK_EN
    input  logic [NUM_ALARMS*ND-1:0] alarm_daymask,
`endif
    output logic [6:0]            tsec,
    output logic [6:0]            tmin,
    output logic [6:0]            thrs,
    output logic [2:0]            tday,
    output logic [6:0]            amin,
    output logic [6:0]            ahrs,
    output logic                  buzz,
    output logic [AW-1:0]         active_idx,
    output logic                  snoozing,
    output logic [1:0]            fsm_state
);

    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam int SW = $clog2(SNOOZE_MIN * NS + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_MIN * NS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t          state;
    logic            tick_d;
    logic [6:0]      al_min [NUM_ALARMS];
    logic [6:0]      al_hr  [NUM_ALARMS];
    logic [RW-1:0]   ring_ct;
    logic [SW-1:0]   snz_ct;
    logic            trig;
    logic [AW-1:0]   trig_idx;
    logic            active_armed;
    logic [NUM_ALARMS-1:0] day_en;

    function automatic logic [6:0] inc_mod(input logic [6:0] v, input int n);
        return (v == 7'(n - 1)) ? 7'd0 : v + 7'd1;
    endfunction

    assign fsm_state = state;

    // Timekeeping and alarm settings; everything moves only on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d <= 1'b0;
            tsec   <= '0;
            tmin   <= '0;
            thrs   <= '0;
            tday   <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_min[i] <= '0;
                al_hr[i]  <= '0;
            end
        end else begin
            tick_d <= tick;
            if (tick) begin
                if (timeset) begin
                    if (minadv) tmin <= inc_mod(tmin, NM);
                    if (hrsadv) thrs <= inc_mod(thrs, NH);
                    if (dayadv) tday <= (tday == 3'(ND - 1)) ? 3'd0 : tday + 3'd1;
                end else begin
                    tsec <= inc_mod(tsec, NS);
                    if (tsec == 7'(NS - 1)) begin
                        tmin <= inc_mod(tmin, NM);
                        if (tmin == 7'(NM - 1)) begin
                            thrs <= inc_mod(thrs, NH);
                            if (thrs == 7'(NH - 1))
                                tday <= (tday == 3'(ND - 1)) ? 3'd0 : tday + 3'd1;
                        end
                    end
                    if (alarmset) begin
                        for (int i = 0; i < NUM_ALARMS; i++) begin
                            if (AW'(i) == alarm_sel) begin
                                if (minadv) al_min[i] <= inc_mod(al_min[i], NM);
                                if (hrsadv) al_hr[i]  <= inc_mod(al_hr[i], NH);
                            end
                        end
                    end
                end
            end
        end
    end

    // Compare one clk after the tick so the freshly updated time is used; lowest index wins.
    always_comb begin
        trig         = 1'b0;
        trig_idx     = '0;
        active_armed = 1'b0;
        day_en       = '1;
        amin         = '0;
        ahrs         = '0;
`ifdef ALARM_DAYMASK_EN
        for (int i = 0; i < NUM_ALARMS; i++)
            day_en[i] = alarm_daymask[i*ND + int'(tday)];
`endif
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (tick_d && !timeset && tsec == 7'd0 && alarm_on[i] && day_en[i] &&
                al_min[i] == tmin && al_hr[i] == thrs) begin
                trig     = 1'b1;
                trig_idx = AW'(i);
            end
        end
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (AW'(i) == active_idx) active_armed = alarm_on[i];
            if (AW'(i) == alarm_sel) begin
                amin = al_min[i];
                ahrs = al_hr[i];
            end
        end
    end

    // Ring/snooze control. Priority: dismiss > disarm > snooze/preempt > timeout/expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            buzz       <= 1'b0;
            snoozing   <= 1'b0;
            active_idx <= '0;
            ring_ct    <= '0;
            snz_ct     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state      <= RINGING;
                        buzz       <= 1'b1;
                        snoozing   <= 1'b0;
                        active_idx <= trig_idx;
                        ring_ct    <= '0;
                    end
                end
                RINGING: begin
                    if (dismiss || !active_armed) begin
                        state    <= IDLE;
                        buzz     <= 1'b0;
                        snoozing <= 1'b0;
                    end else if (snooze) begin
                        state    <= SNOOZE;
                        buzz     <= 1'b0;
                        snoozing <= 1'b1;
                        snz_ct   <= SNZ_LOAD;
                    end else if (tick) begin
                        if (ring_ct == RING_LAST) begin
                            state <= IDLE;
                            buzz  <= 1'b0;
                        end else begin
                            ring_ct <= ring_ct + RW'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss || !active_armed) begin
                        state    <= IDLE;
                        buzz     <= 1'b0;
                        snoozing <= 1'b0;
                    end else if (trig) begin
                        state      <= RINGING;
                        buzz       <= 1'b1;
                        snoozing   <= 1'b0;
                        active_idx <= trig_idx;
                        ring_ct    <= '0;
                    end else if (tick) begin
                        if (snz_ct < SW'(2)) begin
                            state    <= RINGING;
                            buzz     <= 1'b1;
                            snoozing <= 1'b0;
                            ring_ct  <= '0;
                        end else begin
                            snz_ct <= snz_ct - SW'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    buzz     <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: table vectors, directed ring/snooze sequences, random stimulus vs. a seconds-of-week model.
module tb_alarm_clock_multi;

    localparam int NS = 60, NM = 60, NH = 24, ND = 7, NA = 4;
    localparam int SNZ_MIN = 1, RTO = 5;
    localparam int WEEK = NS * NM * NH * ND;

    logic clk = 1'b0;
    logic rst_n, tick, timeset, alarmset, minadv, hrsadv, dayadv, snooze, dismiss;
    logic [1:0] alarm_sel;
    logic [3:0] alarm_on;
    logic [6:0] tsec, tmin, thrs, amin, ahrs;
    logic [2:0] tday;
    logic buzz, snoozing;
    logic [1:0] active_idx, fsm_state;

    int checks = 0;
    int failures = 0;

    alarm_clock_multi #(
        .NS(NS), .NM(NM), .NH(NH), .ND(ND), .NUM_ALARMS(NA),
        .SNOOZE_MIN(SNZ_MIN), .RING_TIMEOUT_S(RTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .timeset(timeset), .alarmset(alarmset),
        .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv), .alarm_sel(alarm_sel),
        .alarm_on(alarm_on), .snooze(snooze), .dismiss(dismiss),
        .tsec(tsec), .tmin(tmin), .thrs(thrs), .tday(tday), .amin(amin), .ahrs(ahrs),
        .buzz(buzz), .active_idx(active_idx), .snoozing(snoozing), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Reference model: time is a single count of seconds within the week.
    int tw;
    int al_min [NA];
    int al_hr  [NA];
    int m_tick_d;
    int mode;          // 0 quiet, 1 ringing, 2 snoozing
    int aidx, ring_el, snz_left;

    function automatic int f_sec();  return tw % NS; endfunction
    function automatic int f_min();  return (tw / NS) % NM; endfunction
    function automatic int f_hr();   return (tw / (NS * NM)) % NH; endfunction
    function automatic int f_day();  return tw / (NS * NM * NH); endfunction

    task automatic model_reset();
        tw = 0; m_tick_d = 0; mode = 0; aidx = 0; ring_el = 0; snz_left = 0;
        for (int i = 0; i < NA; i++) begin al_min[i] = 0; al_hr[i] = 0; end
    endtask

    task automatic model_next();
        int trg, s, m, h, d;
        s = f_sec(); m = f_min(); h = f_hr(); d = f_day();
        trg = -1;
        if (m_tick_d == 1 && s == 0 && !timeset)
            for (int i = 0; i < NA; i++)
                if (trg < 0 && alarm_on[i] && al_min[i] == m && al_hr[i] == h) trg = i;
        case (mode)
            0: if (trg >= 0) begin mode = 1; aidx = trg; ring_el = 0; end
            1: begin
                if (dismiss || !alarm_on[aidx]) mode = 0;
                else if (snooze) begin mode = 2; snz_left = SNZ_MIN * NS; end
                else if (tick) begin
                    ring_el++;
                    if (ring_el >= RTO) mode = 0;
                end
            end
            default: begin
                if (dismiss || !alarm_on[aidx]) mode = 0;
                else if (trg >= 0) begin mode = 1; aidx = trg; ring_el = 0; end
                else if (tick) begin
                    snz_left--;
                    if (snz_left == 0) begin mode = 1; ring_el = 0; end
                end
            end
        endcase
        if (tick) begin
            if (timeset) begin
                if (minadv) m = (m + 1) % NM;
                if (hrsadv) h = (h + 1) % NH;
                if (dayadv) d = (d + 1) % ND;
                tw = ((d * NH + h) * NM + m) * NS + s;
            end else begin
                tw = (tw + 1) % WEEK;
                if (alarmset) begin
                    if (minadv) al_min[alarm_sel] = (al_min[alarm_sel] + 1) % NM;
                    if (hrsadv) al_hr[alarm_sel]  = (al_hr[alarm_sel] + 1) % NH;
                end
            end
        end
        m_tick_d = tick ? 1 : 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_tsec", 32'(tsec), 32'(f_sec()));
        check("m_tmin", 32'(tmin), 32'(f_min()));
        check("m_thrs", 32'(thrs), 32'(f_hr()));
        check("m_tday", 32'(tday), 32'(f_day()));
        check("m_amin", 32'(amin), 32'(al_min[alarm_sel]));
        check("m_ahrs", 32'(ahrs), 32'(al_hr[alarm_sel]));
        check("m_buzz", 32'(buzz), 32'(mode == 1));
        check("m_snoozing", 32'(snoozing), 32'(mode == 2));
        if (mode != 0) check("m_active_idx", 32'(active_idx), 32'(aidx));
    endtask

    task automatic step(input logic tk);
        tick = tk;
        model_next();
        @(posedge clk);
        #1;
        compare_model();
        tick = 1'b0;
    endtask

    task automatic tick_once();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic clear_inputs();
        tick = 0; timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0; dayadv = 0;
        snooze = 0; dismiss = 0; alarm_sel = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        alarm_on = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_time(input int th, input int tm);
        int n = 0;
        timeset = 1;
        while ((f_hr() != th || f_min() != tm) && n < 200) begin
            minadv = (f_min() != tm);
            hrsadv = (f_hr() != th);
            tick_once();
            n++;
        end
        if (n >= 200) check("set_time_bound", 32'(n), 32'(0));
        timeset = 0; minadv = 0; hrsadv = 0;
    endtask

    task automatic set_alarm(input int idx, input int ah, input int am);
        int n = 0;
        alarmset = 1;
        alarm_sel = 2'(idx);
        while ((al_hr[idx] != ah || al_min[idx] != am) && n < 200) begin
            minadv = (al_min[idx] != am);
            hrsadv = (al_hr[idx] != ah);
            tick_once();
            n++;
        end
        if (n >= 200) check("set_alarm_bound", 32'(n), 32'(0));
        alarmset = 0; minadv = 0; hrsadv = 0;
    endtask

    task automatic run_to_sec0();
        int n = 0;
        do begin
            tick_once();
            n++;
        end while (f_sec() != 0 && n < NS + 2);
        if (n >= NS + 2) check("run_to_sec0_bound", 32'(n), 32'(0));
    endtask

    typedef struct {
        logic ts, as, mn, hr, dy;
        logic [1:0] sel;
        int e_sec, e_min, e_hr, e_day, e_amin, e_ahr;
    } vec_t;

    function automatic vec_t mk(input logic ts, input logic as, input logic mn, input logic hr,
                                input logic dy, input logic [1:0] sel, input int s, input int m,
                                input int h, input int d, input int am, input int ah);
        vec_t v;
        v.ts = ts; v.as = as; v.mn = mn; v.hr = hr; v.dy = dy; v.sel = sel;
        v.e_sec = s; v.e_min = m; v.e_hr = h; v.e_day = d; v.e_amin = am; v.e_ahr = ah;
        return v;
    endfunction

    initial begin
        vec_t vecs [8];
        vecs[0] = mk(1, 0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        vecs[1] = mk(1, 0, 0, 1, 1, 2'd0, 0, 1, 1, 1, 0, 0);
        vecs[2] = mk(1, 0, 1, 1, 1, 2'd0, 0, 2, 2, 2, 0, 0);
        vecs[3] = mk(0, 1, 0, 1, 0, 2'd3, 1, 2, 2, 2, 0, 1);
        vecs[4] = mk(0, 1, 1, 1, 0, 2'd3, 2, 2, 2, 2, 1, 2);
        vecs[5] = mk(0, 1, 1, 0, 0, 2'd1, 3, 2, 2, 2, 1, 0);
        vecs[6] = mk(0, 0, 0, 0, 0, 2'd3, 4, 2, 2, 2, 1, 2);
        vecs[7] = mk(1, 1, 1, 0, 0, 2'd0, 4, 3, 2, 2, 0, 0);

        rst_n = 1'b0;
        clear_inputs();
        alarm_on = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tsec", 32'(tsec), 0);
        check("rst_tmin", 32'(tmin), 0);
        check("rst_thrs", 32'(thrs), 0);
        check("rst_tday", 32'(tday), 0);
        check("rst_amin", 32'(amin), 0);
        check("rst_buzz", 32'(buzz), 0);
        check("rst_snoozing", 32'(snoozing), 0);
        check("rst_active_idx", 32'(active_idx), 0);
        rst_n = 1'b1;

        // Set-mode vectors, one tick each.
        for (int i = 0; i < 8; i++) begin
            timeset = vecs[i].ts; alarmset = vecs[i].as; minadv = vecs[i].mn;
            hrsadv = vecs[i].hr; dayadv = vecs[i].dy; alarm_sel = vecs[i].sel;
            tick_once();
            check($sformatf("vec%0d_tsec", i), 32'(tsec), 32'(vecs[i].e_sec));
            check($sformatf("vec%0d_tmin", i), 32'(tmin), 32'(vecs[i].e_min));
            check($sformatf("vec%0d_thrs", i), 32'(thrs), 32'(vecs[i].e_hr));
            check($sformatf("vec%0d_tday", i), 32'(tday), 32'(vecs[i].e_day));
            check($sformatf("vec%0d_amin", i), 32'(amin), 32'(vecs[i].e_amin));
            check($sformatf("vec%0d_ahrs", i), 32'(ahrs), 32'(vecs[i].e_ahr));
        end
        clear_inputs();

        // Rollover and no-carry minute advance.
        do_reset();
        set_time(23, 59);
        timeset = 1; minadv = 1;
        tick_once();
        timeset = 0; minadv = 0;
        check("setmin_wrap_tmin", 32'(tmin), 0);
        check("setmin_wrap_thrs", 32'(thrs), 23);
        check("setmin_wrap_tsec", 32'(tsec), 0);
        set_time(23, 59);
        for (int i = 0; i < 60; i++) tick_once();
        check("roll_tsec", 32'(tsec), 0);
        check("roll_tmin", 32'(tmin), 0);
        check("roll_thrs", 32'(thrs), 0);
        check("roll_tday", 32'(tday), 1);

        // Two alarms on the same minute: lowest index rings.
        do_reset();
        set_alarm(0, 7, 0);
        set_alarm(2, 7, 0);
        alarm_on = 4'b0101;
        set_time(6, 59);
        run_to_sec0();
        check("pre_buzz", 32'(buzz), 1);
        check("pre_idx", 32'(active_idx), 0);
        dismiss = 1; step(1'b0); dismiss = 0;
        check("dismiss_buzz", 32'(buzz), 0);

        // Snooze for one minute, then alarm1 preempts a second snooze.
        set_alarm(1, 7, 2);
        alarm_on = 4'b0111;
        set_time(6, 59);
        run_to_sec0();
        check("snz_ring_buzz", 32'(buzz), 1);
        tick_once(); tick_once();
        snooze = 1; step(1'b0); snooze = 0;
        check("snz_enter_snoozing", 32'(snoozing), 1);
        check("snz_enter_buzz", 32'(buzz), 0);
        for (int i = 0; i < 60; i++) begin
            tick_once();
            if (i < 59) check($sformatf("snz_hold%0d", i), 32'(snoozing), 1);
        end
        check("snz_expire_buzz", 32'(buzz), 1);
        check("snz_expire_snoozing", 32'(snoozing), 0);
        snooze = 1; step(1'b0); snooze = 0;
        run_to_sec0();
        check("preempt_buzz", 32'(buzz), 1);
        check("preempt_idx", 32'(active_idx), 1);
        check("preempt_snoozing", 32'(snoozing), 0);

        // Ring timeout after five ticks, no re-trigger in the same minute.
        for (int i = 1; i <= 5; i++) begin
            tick_once();
            check($sformatf("timeout_t%0d", i), 32'(buzz), 32'(i < 5));
        end
        for (int i = 0; i < 40; i++) tick_once();
        check("timeout_no_retrig", 32'(buzz), 0);

        // Dismiss and snooze together favour dismiss.
        set_time(6, 59);
        run_to_sec0();
        check("ds_ring", 32'(buzz), 1);
        dismiss = 1; snooze = 1; step(1'b0); dismiss = 0; snooze = 0;
        check("ds_buzz", 32'(buzz), 0);
        check("ds_snoozing", 32'(snoozing), 0);

        // Disarming the ringing alarm stops it.
        set_time(6, 59);
        run_to_sec0();
        alarm_on = 4'b0110; step(1'b0); alarm_on = 4'b0111;
        check("disarm_buzz", 32'(buzz), 0);

        // Asynchronous reset while ringing.
        set_time(6, 59);
        run_to_sec0();
        check("mr_ring", 32'(buzz), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_buzz", 32'(buzz), 0);
        check("mr_tsec", 32'(tsec), 0);
        check("mr_tmin", 32'(tmin), 0);
        check("mr_thrs", 32'(thrs), 0);
        check("mr_ahrs", 32'(ahrs), 0);
        check("mr_snoozing", 32'(snoozing), 0);
        check("mr_idx", 32'(active_idx), 0);
        clear_inputs();
        alarm_on = 4'b0000;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random stimulus against the model.
        set_alarm(0, 0, 1);
        set_alarm(1, 0, 2);
        set_alarm(3, 0, 3);
        alarm_on = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            timeset   = ($urandom_range(0, 63) == 0);
            alarmset  = ($urandom_range(0, 31) == 0);
            minadv    = ($urandom_range(0, 3) == 0);
            hrsadv    = ($urandom_range(0, 7) == 0);
            dayadv    = ($urandom_range(0, 3) == 0);
            alarm_sel = 2'($urandom_range(0, 3));
            snooze    = ($urandom_range(0, 29) == 0);
            dismiss   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 63) == 0) alarm_on = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 63) == 0) alarm_on = 4'b1111;
            step(1'($urandom_range(0, 1)));
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised successor of the single-alarm digital clock. It provides sec/min/hr/day-of-week timekeeping and NUM_ALARMS independently settable alarms, plus a ringing/snooze/dismiss state machine with ring timeout. It runs on a fast system clock with a 1 Hz tick enable. Outputs are binary; the existing 2-digit display drivers sit downstream.

Parameters:
NS, 60, seconds modulus (≤127)
NM, 60, minutes modulus (≤127)
NH, 24, hours modulus (≤127)
ND, 7, days-of-week modulus (≤8)
NUM_ALARMS, 4, number of alarms (≥2)
SNOOZE_MIN, 9, snooze length in minutes
RING_TIMEOUT_S, 300, seconds of ringing before auto-stop

Ports:
clk  in  1  system clock
rst_n  in  1  reset, active-low
tick  in  1  1-cycle-wide 1 Hz enable
timeset  in  1  time-set mode
alarmset  in  1  alarm-set mode (timeset has priority)
minadv  in  1  advance minutes once per tick in set mode
hrsadv  in  1  advance hours once per tick in set mode
dayadv  in  1  advance day once per tick in timeset mode
alarm_sel  in  AW=$clog2(NUM_ALARMS)  alarm being set/displayed
alarm_on  in  NUM_ALARMS  per-alarm arm bits
snooze  in  1  snooze request (level, sampled per clk)
dismiss  in  1  stop request
tsec, tmin, thrs  out  7  current time
tday  out  3  current day-of-week
amin, ahrs  out  7  alarm[alarm_sel] setting (combinational mux)
buzz  out  1  alarm sounding
active_idx  out  AW  index of the ringing/snoozing alarm
snoozing  out  1  FSM in SNOOZE

Behaviour:
- Reset: asynchronous on rst_n low. All time and alarm registers 0, FSM IDLE, buzz=0, snoozing=0, active_idx=0, internal tick_d=0.
- Registers change only in cycles with tick=1; without tick, all hold.
- Normal mode (timeset=0): tsec wraps NS-1→0 and carries to tmin. tmin wrap carries to thrs. thrs wrap carries to tday (mod ND).
- timeset=1: tsec holds. minadv advances tmin mod NM with no carry. hrsadv advances thrs mod NH with no carry. dayadv advances tday mod ND. Simultaneous adv bits each act independently.
- alarmset=1 and timeset=0: minadv/hrsadv advance alarm[alarm_sel] min/hr mod NM/NH. There is no carry, and the other alarms are untouched. Time keeps running.
- Trigger:
  - tick_d is tick delayed one clk, so compares use the updated registers.
  - Alarm i matches when tick_d=1, tsec=0, tmin/thrs equal alarm i, alarm_on[i]=1 and timeset=0.
  - Lowest matching index wins. At most one trigger per matching minute.
- FSM, IDLE:
  - On trigger: go to RINGING, latch active_idx, clear ring_ct.
- FSM, RINGING:
  - buzz=1; ring_ct increments per tick.
  - dismiss, or alarm_on[active_idx]=0: go to IDLE next clk.
  - Otherwise snooze: go to SNOOZE, load snz_ct=SNOOZE_MIN*NS.
  - Otherwise ring_ct reaching RING_TIMEOUT_S-1 on a tick: go to IDLE.
  - Triggers from other alarms are ignored.
- FSM, SNOOZE:
  - buzz=0, snoozing=1; snz_ct decrements per tick.
  - Reaching 0: go to RINGING, clear ring_ct.
  - dismiss, or alarm_on[active_idx]=0: go to IDLE.
  - A new trigger (any index) preempts: go to RINGING with the new active_idx.
- Priority in the same cycle: dismiss > alarm_on clear > snooze > timeout/snooze-expiry.
- timeset does not disturb the FSM state; it only suppresses new triggers.
- Counter widths: ring_ct and snz_ct are sized $clog2(max+1). Compares are full width.

Optional Feature:
ALARM_DAYMASK_EN
- Defined: adds input alarm_daymask [NUM_ALARMS*ND-1:0]. Bit i*ND+d enables alarm i on day d, and is an extra trigger qualifier.
- Undefined: the port is absent and every armed alarm fires every day.

Test Plan:
- Rollover: rst_n low then high, preset via timeset to 23:59, run 60 ticks from sec 0 → time 00:00:00, tday 0→1.
- Preempt priority: alarm0=07:00 and alarm2=07:00, both armed, time reaches 07:00:00 → buzz=1 one clk after tick, active_idx=0. Dismiss → buzz=0 next clk.
- Snooze cycle: snooze while RINGING with SNOOZE_MIN=1, NS=60 → snoozing=1 for 60 ticks, then buzz=1. Alarm1 matching during SNOOZE → RINGING with active_idx=1.
- Timeout: no input while ringing, RING_TIMEOUT_S=5 → buzz drops after the 5th tick. The same alarm does not re-trigger within that minute.
- Set modes: timeset+minadv at tmin=59 → tmin=0, thrs unchanged, tsec frozen. alarmset+hrsadv with alarm_sel=3 → only alarm3 hours change, and ahrs shows them.
- Mid-ring reset, and dismiss+snooze same cycle: rst_n low while RINGING → buzz=0 immediately and all counters 0. Dismiss and snooze asserted together → IDLE, not SNOOZE.
